vme_bus_timer: RTL and testbench

VME_BUS_TIMER -- requirements
Module: vme_bus_timer

---
 rtl/vme_bus_timer.sv | 189 ++++++++++++++++++
 tb/tb_vme_bus_timer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/vme_bus_timer.sv
// rtl/vme_bus_timer.sv - VME data-transfer watchdog that drives BERR* on an unacknowledged cycle
//
// Ports:
//   clock               system clock (also the VME SYSCLK)
//   reset               asynchronous active-low reset
//   vme_address_strobe  AS*, active-low, asynchronous to clock
//   vme_data_strobe     {DS1*, DS0*}, active-low, asynchronous
//   vme_dtack           DTACK*, active-low, asynchronous
//   vme_berr_in         sampled BERR* line (may be driven by another master/slave)
//   vme_write           WRITE*, low = write
//   vme_address         A[23:1]
//   vme_berr            BERR* drive: 0 = pull low, 1 = release
//   timeout_pulse       one-cycle pulse per timeout
//   timeout_count       saturating count of timeouts since reset
//   fault_address       {A[23:1], WRITE*} of the last timed-out cycle
//
// Optional feature: define VME_BUS_TIMER_CAPTURE_EN to capture fault_address;
// without it fault_address is tied to zero.

module vme_bus_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        vme_address_strobe,
  input  logic [1:0]  vme_data_strobe,
  input  logic        vme_dtack,
  input  logic        vme_berr_in,
  input  logic        vme_write,
  input  logic [22:0] vme_address,
  output logic        vme_berr,
  output logic        timeout_pulse,
  output logic [7:0]  timeout_count,
  output logic [23:0] fault_address
);

  localparam logic [15:0] TIMEOUT_VAL = 16'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    COUNT        = 2'd1,
    ERROR        = 2'd2,
    WAIT_RELEASE = 2'd3
  } state_t;

  // Two-flop synchronizer, bit order {AS*, DS1*, DS0*, DTACK*, BERR*}
  logic [4:0] sync_meta;
  logic [4:0] sync_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_meta <= '1;
      sync_q    <= '1;
    end else begin
      sync_meta <= {vme_address_strobe, vme_data_strobe, vme_dtack, vme_berr_in};
      sync_q    <= sync_meta;
    end
  end

  logic       as_s;
  logic [1:0] ds_s;
  logic       dtack_s;
  logic       berr_in_s;
  logic       strobed;
  logic       released;
  logic       terminated;

  assign as_s       = sync_q[4];
  assign ds_s       = sync_q[3:2];
  assign dtack_s    = sync_q[1];
  assign berr_in_s  = sync_q[0];
  assign strobed    = !as_s && (ds_s != 2'b11);
  assign released   = (ds_s == 2'b11);
  assign terminated = !dtack_s || !berr_in_s;

  // The synchronizer resets to "released", so the real bus is only visible
  // two clocks after reset. settle marks that point; armed stays low until
  // IDLE has seen a quiet bus, so a cycle already running at reset release
  // is parked in WAIT_RELEASE instead of being timed.
  logic [1:0] settle;
  logic       armed;
  logic       armed_next;

  state_t      state;
  state_t      state_next;
  logic [15:0] counter;
  logic [15:0] counter_next;
  logic        berr_next;
  logic        fire;

  always_comb begin
    state_next   = state;
    counter_next = counter;
    berr_next    = vme_berr;
    armed_next   = armed;
    fire         = 1'b0;
    case (state)
      IDLE: begin
        counter_next = '0;
        berr_next    = 1'b1;
        if (settle[1]) begin
          if (strobed) begin
            if (!armed || terminated) begin
              state_next = WAIT_RELEASE;
            end else begin
              state_next   = COUNT;
              counter_next = 16'd1;
            end
          end else begin
            armed_next = 1'b1;
          end
        end
      end
      COUNT: begin
        // Termination outranks the timeout when both land in one cycle.
        if (terminated) begin
          state_next   = WAIT_RELEASE;
          counter_next = '0;
        end else if (!strobed) begin
          state_next   = IDLE;
          counter_next = '0;
        end else if (counter == TIMEOUT_VAL) begin
          state_next   = ERROR;
          counter_next = '0;
          berr_next    = 1'b0;
          fire         = 1'b1;
        end else begin
          counter_next = counter + 16'd1;
        end
      end
      ERROR: begin
        berr_next = 1'b0;
        if (released) begin
          state_next = IDLE;
          berr_next  = 1'b1;
        end
      end
      WAIT_RELEASE: begin
        berr_next = 1'b1;
        if (released) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next   = IDLE;
        counter_next = '0;
        berr_next    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      counter       <= '0;
      vme_berr      <= 1'b1;
      timeout_pulse <= 1'b0;
      timeout_count <= '0;
      settle        <= '0;
      armed         <= 1'b0;
    end else begin
      state         <= state_next;
      counter       <= counter_next;
      vme_berr      <= berr_next;
      timeout_pulse <= fire;
      settle        <= {settle[0], 1'b1};
      armed         <= armed_next;
      if (fire && (timeout_count != 8'hFF)) begin
        timeout_count <= timeout_count + 8'd1;
      end
    end
  end

`ifdef VME_BUS_TIMER_CAPTURE_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fault_address <= '0;
    end else if (fire) begin
      fault_address <= {vme_address, vme_write};
    end
  end
`else
  // Address and WRITE* are only consumed by the capture path.
  logic unused_capture_inputs;
  assign unused_capture_inputs = ^{vme_address, vme_write};
  assign fault_address = '0;
`endif

endmodule

// File: tb/tb_vme_bus_timer.sv
// tb/tb_vme_bus_timer.sv - self-checking bench for vme_bus_timer with TIMEOUT_CYCLES = 16

module tb_vme_bus_timer;

  localparam int T = 16;

  logic        clock = 1'b0;
  logic        reset;
  logic        vme_address_strobe;
  logic [1:0]  vme_data_strobe;
  logic        vme_dtack;
  logic        vme_berr_in;
  logic        vme_write;
  logic [22:0] vme_address;
  logic        vme_berr;
  logic        timeout_pulse;
  logic [7:0]  timeout_count;
  logic [23:0] fault_address;

  int errors = 0;
  int checks = 0;

  vme_bus_timer #(.TIMEOUT_CYCLES(T)) dut (
    .clock              (clock),
    .reset              (reset),
    .vme_address_strobe (vme_address_strobe),
    .vme_data_strobe    (vme_data_strobe),
    .vme_dtack          (vme_dtack),
    .vme_berr_in        (vme_berr_in),
    .vme_write          (vme_write),
    .vme_address        (vme_address),
    .vme_berr           (vme_berr),
    .timeout_pulse      (timeout_pulse),
    .timeout_count      (timeout_count),
    .fault_address      (fault_address)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic bus_idle();
    vme_address_strobe = 1'b1;
    vme_data_strobe    = 2'b11;
    vme_dtack          = 1'b1;
    vme_berr_in        = 1'b1;
  endtask

  task automatic bus_strobe();
    vme_address_strobe = 1'b0;
    vme_data_strobe    = 2'b10;
  endtask

  // Cycle numbers count clock edges after the strobe was driven; an event
  // "at N" is driven just after edge N. 0 means the event never happens.
  typedef struct {
    int          dtack_at;
    int          berrin_at;
    int          hold;
    logic [22:0] addr;
    logic        wr;
    int          exp_first;
    int          exp_last;
    int          exp_pulses;
    int          exp_count;
  } vec_t;

  vec_t vecs[7];

  logic [23:0] exp_fault;
  int first_low, last_low, pulses, misses;

  initial begin
    vecs[0] = '{0,  0,  29, 23'h7FFFFF, 1'b0, 19, 31, 1, 1}; // plain timeout, release 10 clocks later
    vecs[1] = '{5,  0,  25, 23'h000001, 1'b1, 0,  0,  0, 1}; // normal DTACK* termination
    vecs[2] = '{16, 0,  25, 23'h000002, 1'b1, 0,  0,  0, 1}; // DTACK* seen as counter hits limit
    vecs[3] = '{17, 0,  25, 23'h123456, 1'b1, 19, 27, 1, 2}; // DTACK* one clock too late
    vecs[4] = '{0,  16, 25, 23'h000003, 1'b0, 0,  0,  0, 2}; // foreign BERR* termination
    vecs[5] = '{0,  0,  16, 23'h000004, 1'b0, 0,  0,  0, 2}; // released just before timeout
    vecs[6] = '{0,  0,  17, 23'h555555, 1'b1, 19, 19, 1, 3}; // released one clock too late
    exp_fault = '0;

    reset = 1'b1;
    bus_idle();
    vme_write   = 1'b1;
    vme_address = '0;
    #2 reset = 1'b0;
    #1;
    check("reset_berr",  32'(vme_berr), 32'd1);
    check("reset_pulse", 32'(timeout_pulse), 32'd0);
    check("reset_count", 32'(timeout_count), 32'd0);
    check("reset_fault", 32'(fault_address), 32'd0);
    repeat (3) step();
    reset = 1'b1;

    for (int v = 0; v < 7; v++) begin
      bus_idle();
      repeat (5) step();
      vme_address = vecs[v].addr;
      vme_write   = vecs[v].wr;
      bus_strobe();
      first_low = 0;
      last_low  = 0;
      pulses    = 0;
      for (int i = 1; i <= 40; i++) begin
        step();
        if (!vme_berr) begin
          if (first_low == 0) first_low = i;
          last_low = i;
        end
        if (timeout_pulse) begin
          pulses++;
          check($sformatf("v%0d_pulse_with_berr", v), 32'(vme_berr), 32'd0);
        end
        if (i == vecs[v].dtack_at)  vme_dtack = 1'b0;
        if (i == vecs[v].berrin_at) vme_berr_in = 1'b0;
        if (i == vecs[v].hold)      bus_idle();
      end
`ifdef VME_BUS_TIMER_CAPTURE_EN
      if (vecs[v].exp_pulses > 0) exp_fault = {vecs[v].addr, vecs[v].wr};
`endif
      check($sformatf("v%0d_first_berr", v), 32'(first_low), 32'(vecs[v].exp_first));
      check($sformatf("v%0d_last_berr", v),  32'(last_low),  32'(vecs[v].exp_last));
      check($sformatf("v%0d_pulses", v),     32'(pulses),    32'(vecs[v].exp_pulses));
      check($sformatf("v%0d_count", v),      32'(timeout_count), 32'(vecs[v].exp_count));
      check($sformatf("v%0d_fault", v),      32'(fault_address), 32'(exp_fault));
    end

    // Reset during ERROR with strobes held: BERR* must release at once and
    // the held cycle must not be timed again.
    bus_idle();
    vme_address = '0;
    vme_write   = 1'b1;
    repeat (5) step();
    bus_strobe();
    first_low = 0;
    for (int i = 1; i <= 30; i++) begin
      step();
      if (!vme_berr && first_low == 0) first_low = i;
      if (first_low != 0) break;
    end
    check("rst_err_first_berr", 32'(first_low), 32'd19);
    #2 reset = 1'b0;
    #1;
    check("rst_err_async_berr", 32'(vme_berr), 32'd1);
    check("rst_err_count",      32'(timeout_count), 32'd0);
    check("rst_err_fault",      32'(fault_address), 32'd0);
    step();
    step();
    reset = 1'b1;
    last_low = 0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (!vme_berr || timeout_pulse) last_low++;
    end
    check("rst_held_no_berr", 32'(last_low), 32'd0);
    bus_idle();
    repeat (5) step();
    bus_strobe();
    first_low = 0;
    for (int i = 1; i <= 25; i++) begin
      step();
      if (!vme_berr && first_low == 0) first_low = i;
    end
    check("restart_first_berr", 32'(first_low), 32'd19);
    check("restart_count",      32'(timeout_count), 32'd1);
`ifdef VME_BUS_TIMER_CAPTURE_EN
    exp_fault = 24'h000001;
`else
    exp_fault = 24'h000000;
`endif
    check("restart_fault", 32'(fault_address), 32'(exp_fault));

    // Saturation: 255 more timeouts (256 in total) must leave the count at 255.
    misses = 0;
    for (int k = 0; k < 255; k++) begin
      bus_idle();
      repeat (5) step();
      bus_strobe();
      pulses = 0;
      for (int i = 1; i <= 30; i++) begin
        step();
        if (timeout_pulse) pulses++;
        if (pulses != 0) break;
      end
      if (pulses == 0) misses++;
      bus_idle();
      repeat (4) step();
      if (k == 253) check("sat_count_at_255", 32'(timeout_count), 32'd255);
    end
    check("sat_all_timed_out", 32'(misses), 32'd0);
    check("sat_count_final",   32'(timeout_count), 32'd255);
    check("sat_berr_released", 32'(vme_berr), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
